irrigation_timer_ctrl: RTL and testbench
========================================

IRRIGATION_TIMER_CTRL -- requirements
Module: irrigation_timer_ctrl

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 60, meaning tick pulses per one-unit decrement; legal range 2..64.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, level-sampled request to load the preset and begin watering.
REQ-005 The block SHALL have port stop, input, 1, abort of the current watering cycle.
REQ-006 The block SHALL have port pause, input, 1, hold request; watering suspended while high.
REQ-007 The block SHALL have port tick, input, 1, one-clock-wide time-base pulse.
REQ-008 The block SHALL have port load_tens, input, 2, preset tens digit, 0..3.
REQ-009 The block SHALL have port load_units, input, 4, preset units digit, 0..9.
REQ-010 The block SHALL have port tens, output, 2, remaining-time tens digit.
REQ-011 The block SHALL have port units, output, 4, remaining-time units digit (BCD).
REQ-012 The block SHALL have port valve, output, 1, registered valve drive, high only in RUN.
REQ-013 The block SHALL have port busy, output, 1, high in RUN or HOLD.
REQ-014 The block SHALL have port done, output, 1, one-clock pulse on natural expiry.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, HOLD, FINISH; all outputs registered.
REQ-016 IDLE, start=1, stop=0: load tens/units from presets, clear prescaler, go to RUN at that edge; valve=1 from the next cycle.
REQ-017 load_units values 10..15 SHALL be clamped to 9 at load.
REQ-018 Preset 00 with start: go to FINISH instead of RUN; valve never asserted; done pulses the following cycle.
REQ-019 RUN, tick=1: prescaler increments; when prescaler = PRESCALE-1, prescaler wraps to 0 and the count decrements by one in the same edge.
REQ-020 Decrement: units>0 -> units-1; units=0 -> units=9, tens-1 (tens only decremented when nonzero count remains).
REQ-021 Decrement to 00 SHALL move to FINISH at the same edge; valve and busy drop at that edge.
REQ-022 FINISH: done=1 for exactly one cycle, then IDLE; tens/units remain 00.
REQ-023 RUN, pause=1 (stop=0): go to HOLD; valve=0; prescaler and count frozen; tick ignored.
REQ-024 HOLD, pause=0: return to RUN with prescaler and count unchanged.
REQ-025 RUN or HOLD, stop=1: go to IDLE, clear count and prescaler to 0, valve=0, no done pulse.
REQ-026 Priority: stop > pause > tick; in IDLE stop > start (start&stop -> stay IDLE).
REQ-027 start SHALL be ignored outside IDLE; pause and tick ignored in IDLE and FINISH.
REQ-028 tick coinciding with the pause or stop edge SHALL NOT be counted.

Reset
REQ-029 reset low SHALL immediately force IDLE, tens=0, units=0, prescaler=0, valve=0, busy=0, done=0, independent of clock.
REQ-030 Reset asserted mid-RUN or mid-HOLD SHALL discard the cycle without a done pulse; operation resumes only on a new start after reset release.

Verification (PRESCALE=2)
REQ-031 Preset 1/2, start, tick every cycle -> count 12,11,10,09 ... 01,00 every 2 ticks; 24 ticks after start, done pulses once; valve high exactly 24 RUN cycles.
REQ-032 Preset 0/0, start -> FINISH then done=1 one cycle; valve stays 0 throughout.
REQ-033 Preset 3/9 then load_units=12 variant -> loaded 39 and 39 (clamped); count 30 -> 29 on the wrap decrement.
REQ-034 Preset 0/5, after one decrement assert pause 10 cycles with ticks -> count held at 04, valve=0, busy=1; release -> resumes, done after 8 further ticks.
REQ-035 Preset 2/0, mid-RUN stop with simultaneous tick -> IDLE, count 00, no done; start+stop together in IDLE -> stays IDLE.
REQ-036 Mid-RUN reset low asynchronously between edges -> all outputs 0 immediately; after release, outputs stay idle until start.

Source files
------------

// File: rtl/irrigation_timer_ctrl.sv
// Irrigation watering timer: a two-digit BCD countdown (tens 0..3, units 0..9)
// decremented once every PRESCALE tick pulses while the valve is open.
//
// state  | meaning
// IDLE   | waiting for start; count held at the last result (00 after stop/expiry)
// RUN    | valve open; ticks advance the prescaler and decrement the count
// HOLD   | paused; valve closed, prescaler and count frozen
// FINISH | count reached 00; done high for this single cycle
module irrigation_timer_ctrl #(
  parameter int unsigned PRESCALE = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       tick,
  input  logic [1:0] load_tens,
  input  logic [3:0] load_units,
  output logic [1:0] tens,
  output logic [3:0] units,
  output logic       valve,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HOLD   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] ps, ps_n;
  logic [1:0]    tens_n;
  logic [3:0]    units_n;
  logic [3:0]    units_clamped;

  assign units_clamped = (load_units > 4'd9) ? 4'd9 : load_units;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      ps    <= '0;
      tens  <= 2'd0;
      units <= 4'd0;
      valve <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ps    <= ps_n;
      tens  <= tens_n;
      units <= units_n;
      valve <= (state_n == S_RUN);
      busy  <= (state_n == S_RUN) || (state_n == S_HOLD);
      done  <= (state_n == S_FINISH);
    end
  end

  always_comb begin
    state_n = state;
    ps_n    = ps;
    tens_n  = tens;
    units_n = units;
    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          tens_n  = load_tens;
          units_n = units_clamped;
          ps_n    = '0;
          state_n = ((load_tens == 2'd0) && (units_clamped == 4'd0)) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
          tens_n  = 2'd0;
          units_n = 4'd0;
          ps_n    = '0;
        end else if (pause) begin
          state_n = S_HOLD;
        end else if (tick) begin
          if (ps == PS_LAST) begin
            ps_n = '0;
            if (units != 4'd0) begin
              units_n = units - 4'd1;
            end else if (tens != 2'd0) begin
              units_n = 4'd9;
              tens_n  = tens - 2'd1;
            end
            if ((tens_n == 2'd0) && (units_n == 4'd0)) begin
              state_n = S_FINISH;
            end
          end else begin
            ps_n = ps + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_n = S_IDLE;
          tens_n  = 2'd0;
          units_n = 4'd0;
          ps_n    = '0;
        end else if (!pause) begin
          state_n = S_RUN;
        end
      end
      S_FINISH: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_irrigation_timer_ctrl.sv
// Directed bench for irrigation_timer_ctrl at PRESCALE=2: a vector table for
// single-cycle behaviour plus hand sequences for full runs, pause and reset.
module tb_irrigation_timer_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, stop, pause, tick;
  logic [1:0] load_tens;
  logic [3:0] load_units;
  logic [1:0] tens;
  logic [3:0] units;
  logic       valve, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  irrigation_timer_ctrl #(.PRESCALE(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .tick       (tick),
    .load_tens  (load_tens),
    .load_units (load_units),
    .tens       (tens),
    .units      (units),
    .valve      (valve),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       st, sp, pa, tk;
    logic [1:0] lt;
    logic [3:0] lu;
    logic [1:0] et;
    logic [3:0] eu;
    logic       ev, eb, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, sp, pa, tk, input logic [1:0] lt, input logic [3:0] lu,
                     input logic [1:0] et, input logic [3:0] eu, input logic ev, eb, ed);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.tk = tk; v.lt = lt; v.lu = lu;
    v.et = et; v.eu = eu; v.ev = ev; v.eb = eb; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, sp, pa, tk, input logic [1:0] lt, input logic [3:0] lu);
    start = st; stop = sp; pause = pa; tick = tk; load_tens = lt; load_units = lu;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [1:0] et, input logic [3:0] eu,
                     input logic ev, eb, ed);
    n_cmp++;
    if (tens !== et || units !== eu || valve !== ev || busy !== eb || done !== ed) begin
      n_bad++;
      $display("FAIL %s: got tens=%0d units=%0d valve=%b busy=%b done=%b, want tens=%0d units=%0d valve=%b busy=%b done=%b",
               name, tens, units, valve, busy, done, et, eu, ev, eb, ed);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  initial begin
    int valve_cycles;
    int done_pulses;
    int done_step;
    int rem;

    drive(0, 0, 0, 0, 2'd0, 4'd0);
    reset = 1'b0;
    #12;
    chk("reset_state", 2'd0, 4'd0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    step();

    //   st sp pa tk  lt    lu     et    eu    v  b  d
    add(0, 0, 0, 0, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);
    add(1, 1, 0, 0, 2'd1, 4'd2,  2'd0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 2'd1, 4'd2,  2'd1, 4'd2, 1, 1, 0);
    add(0, 0, 0, 1, 2'd1, 4'd2,  2'd1, 4'd2, 1, 1, 0);
    add(0, 0, 0, 1, 2'd1, 4'd2,  2'd1, 4'd1, 1, 1, 0);
    add(1, 0, 0, 0, 2'd3, 4'd3,  2'd1, 4'd1, 1, 1, 0);
    add(0, 0, 1, 1, 2'd0, 4'd0,  2'd1, 4'd1, 0, 1, 0);
    add(0, 0, 1, 1, 2'd0, 4'd0,  2'd1, 4'd1, 0, 1, 0);
    add(0, 0, 0, 0, 2'd0, 4'd0,  2'd1, 4'd1, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd1, 4'd1, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd1, 4'd0, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd1, 4'd0, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd0, 4'd9, 1, 1, 0);
    add(0, 1, 0, 1, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 1);
    add(0, 0, 0, 0, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 2'd0, 4'd15, 2'd0, 4'd9, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd0, 4'd9, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd0, 4'd8, 1, 1, 0);
    add(0, 1, 0, 0, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 2'd0, 4'd1,  2'd0, 4'd1, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd0, 4'd1, 1, 1, 0);
    add(0, 0, 0, 1, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 1);
    add(0, 0, 1, 1, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);
    add(1, 0, 0, 0, 2'd2, 4'd0,  2'd2, 4'd0, 1, 1, 0);
    add(0, 0, 1, 0, 2'd0, 4'd0,  2'd2, 4'd0, 0, 1, 0);
    add(0, 1, 1, 1, 2'd0, 4'd0,  2'd0, 4'd0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].pa, vecs[i].tk, vecs[i].lt, vecs[i].lu);
      step();
      chk($sformatf("vec%0d", i), vecs[i].et, vecs[i].eu, vecs[i].ev, vecs[i].eb, vecs[i].ed);
    end

    // Full 12-unit run with a tick every cycle
    drive(1, 0, 0, 1, 2'd1, 4'd2);
    step();
    chk("run12_load", 2'd1, 4'd2, 1, 1, 0);
    valve_cycles = valve ? 1 : 0;
    done_pulses = 0;
    done_step = -1;
    start = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      step();
      if (valve) valve_cycles++;
      if (done) begin
        done_pulses++;
        done_step = i;
      end
      if (i <= 24) begin
        rem = 12 - i / 2;
        chk($sformatf("run12_t%0d", i), 2'(rem / 10), 4'(rem % 10),
            (i < 24), (i < 24), (i == 24));
      end
    end
    chk_int("run12_valve_cycles", valve_cycles, 24);
    chk_int("run12_done_pulses", done_pulses, 1);
    chk_int("run12_done_step", done_step, 24);
    chk("run12_idle_after", 2'd0, 4'd0, 0, 0, 0);

    // Units clamp and tens wrap
    drive(1, 0, 0, 0, 2'd3, 4'd9);
    step();
    chk("load39", 2'd3, 4'd9, 1, 1, 0);
    drive(0, 1, 0, 0, 2'd0, 4'd0);
    step();
    drive(1, 0, 0, 0, 2'd3, 4'd12);
    step();
    chk("load3_12_clamp", 2'd3, 4'd9, 1, 1, 0);
    drive(0, 0, 0, 1, 2'd0, 4'd0);
    for (int i = 0; i < 18; i++) step();
    chk("count30", 2'd3, 4'd0, 1, 1, 0);
    step();
    step();
    chk("count29", 2'd2, 4'd9, 1, 1, 0);
    drive(0, 1, 0, 0, 2'd0, 4'd0);
    step();
    chk("stop_after29", 2'd0, 4'd0, 0, 0, 0);

    // Pause holds count while ticks keep arriving
    drive(1, 0, 0, 0, 2'd0, 4'd5);
    step();
    drive(0, 0, 0, 1, 2'd0, 4'd0);
    step();
    step();
    chk("pause_pre04", 2'd0, 4'd4, 1, 1, 0);
    drive(0, 0, 1, 1, 2'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("pause_hold%0d", i), 2'd0, 4'd4, 0, 1, 0);
    end
    drive(0, 0, 0, 0, 2'd0, 4'd0);
    step();
    chk("pause_release", 2'd0, 4'd4, 1, 1, 0);
    tick = 1'b1;
    done_step = -1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (done && done_step < 0) done_step = i;
    end
    chk_int("pause_done_after_ticks", done_step, 8);
    drive(0, 0, 0, 0, 2'd0, 4'd0);
    step();
    chk("pause_idle_after", 2'd0, 4'd0, 0, 0, 0);

    // Asynchronous reset mid-run
    drive(1, 0, 0, 0, 2'd2, 4'd0);
    step();
    drive(0, 0, 0, 1, 2'd0, 4'd0);
    step();
    step();
    step();
    chk("prereset_19", 2'd1, 4'd9, 1, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_now", 2'd0, 4'd0, 0, 0, 0);
    step();
    chk("reset_held", 2'd0, 4'd0, 0, 0, 0);
    reset = 1'b1;
    done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) done_pulses++;
    end
    chk("post_reset_idle", 2'd0, 4'd0, 0, 0, 0);
    chk_int("post_reset_no_done", done_pulses, 0);
    drive(1, 0, 0, 0, 2'd0, 4'd3);
    step();
    chk("post_reset_start", 2'd0, 4'd3, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
